aura_mem_arbiter: RTL and testbench

//  Shares AURA's single tagged memory port among four streams: Q/K/V tile loaders (load-only) and the O writer (store-only).

---
 rtl/aura_pkg.sv | 44 ++++
 rtl/aura_rr_arbiter.sv | 29 ++
 rtl/aura_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_aura_mem_arbiter.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aura_pkg.sv
// Shared types and constants for the AURA memory-port arbiter: memory
// interface types, requester indices and the load tag-table entry.
package aura_pkg;

    localparam int NUM_REQ         = 4;
    localparam int NUM_TAGS        = 16;
    localparam int MAX_OUTSTANDING = 8;

    localparam int REQ_IDX_W = $clog2(NUM_REQ);
    localparam int TAG_W     = $clog2(NUM_TAGS);
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int ADDR_W    = 32;
    localparam int BLOCK_W   = 64;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef logic [ADDR_W-1:0]    ADDR;
    typedef logic [BLOCK_W-1:0]   MEM_BLOCK;
    typedef logic [TAG_W-1:0]     MEM_TAG;
    typedef logic [REQ_IDX_W-1:0] req_idx_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    // Requester slots: three tile loaders and the output writer.
    localparam req_idx_t REQ_Q = req_idx_t'(0);
    localparam req_idx_t REQ_K = req_idx_t'(1);
    localparam req_idx_t REQ_V = req_idx_t'(2);
    localparam req_idx_t REQ_O = req_idx_t'(3);

    // One tag-table slot: is a load in flight on this tag, and whose is it.
    typedef struct packed {
        logic     valid;
        req_idx_t owner;
    } TAG_ENTRY_t;

    // Round-robin successor, wrapping at NUM_REQ (not necessarily a power of 2).
    function automatic req_idx_t next_idx(input req_idx_t i);
        return (i == req_idx_t'(NUM_REQ - 1)) ? '0 : req_idx_t'(i + 1'b1);
    endfunction

endpackage

// File: rtl/aura_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester at
// or after the priority pointer, wrapping around. Grant is one-hot or zero.
module aura_rr_arbiter
    import aura_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible,
    input  req_idx_t           ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic     found;
    req_idx_t idx;

    // Walk the ring starting at the pointer; the first eligible slot wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch can be inferred.
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/aura_mem_arbiter.sv
// Shares the single tagged memory port among the Q/K/V tile loaders and the
// O writer. One request per cycle is granted round-robin; each accepted load
// is recorded against its memory tag so out-of-order data can be routed back
// to the loader that issued it.
module aura_mem_arbiter
    import aura_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  MEM_COMMAND          req_cmd [NUM_REQ],
    input  ADDR                 req_addr [NUM_REQ],
    input  MEM_BLOCK            req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]  req_ack,
    output logic [NUM_REQ-1:0]  rsp_valid,
    output MEM_BLOCK            rsp_data,
    output MEM_COMMAND          proc2mem_command,
    output ADDR                 proc2mem_addr,
    output MEM_BLOCK            proc2mem_data,
    input  MEM_TAG              mem2proc_transaction_tag,
    input  MEM_BLOCK            mem2proc_data,
    input  MEM_TAG              mem2proc_data_tag,
    output logic                idle,
    output logic                err_tag_reuse
);

    TAG_ENTRY_t tag_table_q [NUM_TAGS];
    TAG_ENTRY_t tag_table_d [NUM_TAGS];
    cnt_t       outstanding_q [NUM_REQ];
    cnt_t       outstanding_d [NUM_REQ];
    req_idx_t   rr_ptr_q, rr_ptr_d;
    logic       err_tag_reuse_q, err_tag_reuse_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               any_grant;
    req_idx_t           win_idx;
    logic               accept;
    logic               accept_load;
    TAG_ENTRY_t         rsp_entry;
    logic               rsp_hit;
    logic               none_outstanding;

    // A loader at its in-flight limit sits out; nothing is eligible while reset
    // is asserted so the memory port reads MEM_NONE during reset.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = rst_n && req_valid[i] &&
                          ((req_cmd[i] != MEM_LOAD) ||
                           (outstanding_q[i] < cnt_t'(MAX_OUTSTANDING)));
        end
    end

    aura_rr_arbiter u_rr_arbiter (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .grant    (grant)
    );

    // Winner drives the memory port this cycle; memory acceptance is the ack.
    always_comb begin
        any_grant = |grant;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_idx = req_idx_t'(i);
        end
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (any_grant) begin
            proc2mem_command = req_cmd[win_idx];
            proc2mem_addr    = req_addr[win_idx];
            proc2mem_data    = req_data[win_idx];
        end
        accept      = any_grant && (mem2proc_transaction_tag != '0);
        accept_load = accept && (req_cmd[win_idx] == MEM_LOAD);
        req_ack     = accept ? grant : '0;
    end

    // Route returning data to the loader that owns the tag; unknown tags drop.
    always_comb begin
        rsp_entry = tag_table_q[mem2proc_data_tag];
        rsp_hit   = (mem2proc_data_tag != '0) && rsp_entry.valid;
        rsp_valid = '0;
        rsp_data  = '0;
        if (rsp_hit) begin
            rsp_valid[rsp_entry.owner] = 1'b1;
            rsp_data                   = mem2proc_data;
        end
    end

    // Bookkeeping update: retire the responding tag, then record a new load.
    always_comb begin
        tag_table_d     = tag_table_q;
        rr_ptr_d        = rr_ptr_q;
        err_tag_reuse_d = err_tag_reuse_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Accept and response for the same requester cancel out.
            outstanding_d[i] = outstanding_q[i]
                             + cnt_t'(accept_load && (win_idx == req_idx_t'(i)))
                             - cnt_t'(rsp_hit && (rsp_entry.owner == req_idx_t'(i)));
        end
        if (rsp_hit) tag_table_d[mem2proc_data_tag].valid = 1'b0;
        if (accept) rr_ptr_d = next_idx(win_idx);
        if (accept_load) begin
            // Memory handed out a tag we still consider live: flag it, keep the newest owner.
            if (tag_table_q[mem2proc_transaction_tag].valid) err_tag_reuse_d = 1'b1;
            tag_table_d[mem2proc_transaction_tag] = '{valid: 1'b1, owner: win_idx};
        end
    end

    // State registers; reset discards all in-flight bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the tag table is reset on purpose -- stale valid bits would misroute late responses.
            for (int t = 0; t < NUM_TAGS; t++) tag_table_q[t] <= '0;
            for (int i = 0; i < NUM_REQ; i++) outstanding_q[i] <= '0;
            rr_ptr_q        <= '0;
            err_tag_reuse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            tag_table_q     <= tag_table_d;
            outstanding_q   <= outstanding_d;
            rr_ptr_q        <= rr_ptr_d;
            err_tag_reuse_q <= err_tag_reuse_d;
        end
    end

    // Idle when nobody is asking and no load is awaiting data.
    always_comb begin
        none_outstanding = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (outstanding_q[i] != '0) none_outstanding = 1'b0;
        end
        idle          = !rst_n || (!(|req_valid) && none_outstanding);
        err_tag_reuse = err_tag_reuse_q;
    end

endmodule

// File: tb/tb_aura_mem_arbiter.sv
// Bench for aura_mem_arbiter: directed scenarios with literal expectations,
// then randomized requesters and an out-of-order memory, all compared every
// cycle against a behavioural model of the arbitration and tag bookkeeping.
module tb_aura_mem_arbiter;
    import aura_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_REQ-1:0] req_valid;
    MEM_COMMAND         req_cmd [NUM_REQ];
    ADDR                req_addr [NUM_REQ];
    MEM_BLOCK           req_data [NUM_REQ];
    logic [NUM_REQ-1:0] req_ack, rsp_valid;
    MEM_BLOCK           rsp_data;
    MEM_COMMAND         proc2mem_command;
    ADDR                proc2mem_addr;
    MEM_BLOCK           proc2mem_data;
    MEM_TAG             mem2proc_transaction_tag, mem2proc_data_tag;
    MEM_BLOCK           mem2proc_data;
    logic               idle, err_tag_reuse;

    aura_mem_arbiter dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .req_valid                (req_valid),
        .req_cmd                  (req_cmd),
        .req_addr                 (req_addr),
        .req_data                 (req_data),
        .req_ack                  (req_ack),
        .rsp_valid                (rsp_valid),
        .rsp_data                 (rsp_data),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .proc2mem_data            (proc2mem_data),
        .mem2proc_transaction_tag (mem2proc_transaction_tag),
        .mem2proc_data            (mem2proc_data),
        .mem2proc_data_tag        (mem2proc_data_tag),
        .idle                     (idle),
        .err_tag_reuse            (err_tag_reuse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ptr;
    int m_out [NUM_REQ];
    int m_own [NUM_TAGS];   // -1 = no load in flight on this tag
    bit m_err;
    bit p_valid, p_acc, p_load, p_hit;
    int p_win, p_tag, p_htag, p_howner;

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NUM_REQ; i++) m_out[i] = 0;
        for (int t = 0; t < NUM_TAGS; t++) m_own[t] = -1;
        m_err   = 1'b0;
        p_valid = 1'b0;
    endtask

    always @(negedge rst_n) model_reset();

    int                 c_win, c_tag, c_dtag, c_j;
    bit                 c_acc, c_hit, c_idle;
    logic [NUM_REQ-1:0] c_ack, c_rsp;
    MEM_COMMAND         c_cmd;

    // Compare process: predicts this cycle's outputs from the model state.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
            check("rst_addr", 64'(proc2mem_addr), 64'd0);
            check("rst_data", proc2mem_data, 64'd0);
            check("rst_ack", 64'(req_ack), 64'd0);
            check("rst_rsp", 64'(rsp_valid), 64'd0);
            check("rst_idle", 64'(idle), 64'd1);
            check("rst_err", 64'(err_tag_reuse), 64'd0);
            p_valid = 1'b0;
        end else begin
            c_win = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                c_j = (m_ptr + k) % NUM_REQ;
                if (c_win < 0 && req_valid[c_j] &&
                    (req_cmd[c_j] != MEM_LOAD || m_out[c_j] < MAX_OUTSTANDING)) c_win = c_j;
            end
            c_tag  = int'(mem2proc_transaction_tag);
            c_dtag = int'(mem2proc_data_tag);
            c_acc  = (c_win >= 0) && (c_tag != 0);
            c_hit  = (c_dtag != 0) && (m_own[c_dtag] >= 0);
            c_cmd  = MEM_NONE;
            c_ack  = '0;
            c_rsp  = '0;
            if (c_win >= 0) c_cmd = req_cmd[c_win];
            if (c_acc) c_ack[c_win] = 1'b1;
            if (c_hit) c_rsp[m_own[c_dtag]] = 1'b1;
            c_idle = (req_valid == '0);
            for (int i = 0; i < NUM_REQ; i++) if (m_out[i] != 0) c_idle = 1'b0;

            check("cmd", 64'(proc2mem_command), 64'(c_cmd));
            if (c_win >= 0) begin
                check("addr", 64'(proc2mem_addr), 64'(req_addr[c_win]));
                check("wdata", proc2mem_data, req_data[c_win]);
            end
            check("ack", 64'(req_ack), 64'(c_ack));
            check("rsp_valid", 64'(rsp_valid), 64'(c_rsp));
            if (c_hit) check("rsp_data", rsp_data, mem2proc_data);
            check("idle", 64'(idle), 64'(c_idle));
            check("err_tag_reuse", 64'(err_tag_reuse), 64'(m_err));

            p_valid  = 1'b1;
            p_acc    = c_acc;
            p_win    = c_win;
            p_tag    = c_tag;
            p_load   = 1'b0;
            if (c_acc) p_load = (req_cmd[c_win] == MEM_LOAD);
            p_hit    = c_hit;
            p_htag   = c_dtag;
            p_howner = c_hit ? m_own[c_dtag] : 0;
        end
    end

    // Model state advance at the clock edge.
    always @(posedge clk) begin
        if (rst_n && p_valid) begin
            if (p_load && m_own[p_tag] >= 0) m_err = 1'b1;
            if (p_hit) begin
                m_own[p_htag] = -1;
                m_out[p_howner]--;
            end
            if (p_acc) begin
                m_ptr = (p_win + 1) % NUM_REQ;
                if (p_load) begin
                    m_own[p_tag] = p_win;
                    m_out[p_win]++;
                end
            end
            p_valid = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    int mq_tag [$];   // tags the memory model has accepted loads on and not yet answered

    task automatic idle_inputs();
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_cmd[i]  = MEM_NONE;
            req_addr[i] = '0;
            req_data[i] = '0;
        end
        mem2proc_transaction_tag = '0;
        mem2proc_data_tag        = '0;
        mem2proc_data            = '0;
    endtask

    task automatic set_req(input int i, input ADDR a, input MEM_BLOCK d);
        req_valid[i] = 1'b1;
        req_cmd[i]   = (i == int'(REQ_O)) ? MEM_STORE : MEM_LOAD;
        req_addr[i]  = a;
        req_data[i]  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();
        mq_tag.delete();
    endtask

    task automatic run_random(input int cycles, input int req_pct, input int acc_pct,
                              input int rsp_pct, input int reset_at);
        logic [NUM_REQ-1:0] s_ack;
        MEM_COMMAND         s_cmd;
        int                 s_tag, s_dtag, pick;
        int                 free_tags [$];
        bit                 busy;
        ADDR                a;
        for (int c = 0; c < cycles; c++) begin
            sample();
            s_ack  = req_ack;
            s_cmd  = proc2mem_command;
            s_tag  = int'(mem2proc_transaction_tag);
            s_dtag = int'(mem2proc_data_tag);
            next_cycle();
            if (s_dtag != 0) begin
                for (int q = 0; q < mq_tag.size(); q++) begin
                    if (mq_tag[q] == s_dtag) begin
                        mq_tag.delete(q);
                        break;
                    end
                end
            end
            if (s_cmd == MEM_LOAD && s_ack != '0) mq_tag.push_back(s_tag);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (s_ack[i] || !req_valid[i]) begin
                    if (int'($urandom_range(99)) < req_pct) begin
                        a = $urandom();
                        a[2:0] = 3'b000;
                        set_req(i, a, {$urandom(), $urandom()});
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            mem2proc_transaction_tag = '0;
            if (int'($urandom_range(99)) < acc_pct) begin
                free_tags.delete();
                for (int t = 1; t < NUM_TAGS; t++) begin
                    busy = 1'b0;
                    foreach (mq_tag[q]) if (mq_tag[q] == t) busy = 1'b1;
                    if (!busy) free_tags.push_back(t);
                end
                if (free_tags.size() > 0) begin
                    pick = int'($urandom_range(free_tags.size() - 1));
                    mem2proc_transaction_tag = MEM_TAG'(free_tags[pick]);
                end
            end
            mem2proc_data_tag = '0;
            mem2proc_data     = {$urandom(), $urandom()};
            if (mq_tag.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
                pick = int'($urandom_range(mq_tag.size() - 1));
                mem2proc_data_tag = MEM_TAG'(mq_tag[pick]);
            end
            if (c == reset_at) rst_n = 1'b0;
            if (c == reset_at + 2) rst_n = 1'b1;
        end
    endtask

    // ---------------- scenarios ----------------
    int                 ack_cnt [NUM_REQ];
    int                 prev_tag;
    logic [NUM_REQ-1:0] exp_onehot;

    initial begin
        rst_n = 1'b0;
        model_reset();
        idle_inputs();

        // Single K load, out-of-order-capable return eight cycles later.
        do_reset();
        sample();
        check("t1_idle_after_reset", 64'(idle), 64'd1);
        next_cycle();
        set_req(1, 32'h0000_1000, '0);
        mem2proc_transaction_tag = 4'd3;
        sample();
        check("t1_ack_k", 64'(req_ack), 64'h2);
        check("t1_cmd_load", 64'(proc2mem_command), 64'(MEM_LOAD));
        check("t1_addr", 64'(proc2mem_addr), 64'h1000);
        next_cycle();
        idle_inputs();
        sample();
        check("t1_busy", 64'(idle), 64'd0);
        repeat (7) next_cycle();
        mem2proc_data_tag = 4'd3;
        mem2proc_data     = 64'hDEAD_BEEF_0000_1000;
        sample();
        check("t1_rsp_k", 64'(rsp_valid), 64'h2);
        check("t1_rsp_data", rsp_data, 64'hDEAD_BEEF_0000_1000);
        next_cycle();
        idle_inputs();
        sample();
        check("t1_idle_again", 64'(idle), 64'd1);

        // All four requesting, memory always accepting: strict rotation.
        next_cycle();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) ack_cnt[i] = 0;
        prev_tag = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR'(c * 64 + i * 8), MEM_BLOCK'(c));
            mem2proc_transaction_tag = MEM_TAG'((c % 15) + 1);
            mem2proc_data_tag        = MEM_TAG'(prev_tag);
            mem2proc_data            = MEM_BLOCK'(c);
            sample();
            exp_onehot = '0;
            exp_onehot[c % 4] = 1'b1;
            check("t2_rotation", 64'(req_ack), 64'(exp_onehot));
            for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) ack_cnt[i]++;
            prev_tag = (c % 4 != 3) ? (c % 15) + 1 : 0;
            next_cycle();
        end
        for (int i = 0; i < NUM_REQ; i++) check("t2_ack_count", 64'(ack_cnt[i]), 64'd100);

        // Refused request keeps priority over the next requester.
        do_reset();
        set_req(0, 32'h2000, '0);
        mem2proc_transaction_tag = 4'd1;
        sample();
        check("t3_q_first", 64'(req_ack), 64'h1);
        next_cycle();
        req_valid = '0;
        set_req(1, 32'h3000, '0);
        set_req(2, 32'h4000, '0);
        mem2proc_transaction_tag = 4'd0;
        sample();
        check("t3_refused", 64'(req_ack), 64'h0);
        check("t3_k_on_port", 64'(proc2mem_addr), 64'h3000);
        next_cycle();
        mem2proc_transaction_tag = 4'd2;
        sample();
        check("t3_k_again", 64'(req_ack), 64'h2);
        next_cycle();
        req_valid[1] = 1'b0;
        mem2proc_transaction_tag = 4'd4;
        sample();
        check("t3_v_next", 64'(req_ack), 64'h4);

        // Q saturates at eight loads; O still served; one response frees Q.
        next_cycle();
        do_reset();
        for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            set_req(0, ADDR'(32'h100 + k * 8), '0);
            mem2proc_transaction_tag = MEM_TAG'(k + 1);
            sample();
            check("t4_q_load", 64'(req_ack), 64'h1);
            next_cycle();
        end
        mem2proc_transaction_tag = 4'd9;
        for (int k = 0; k < 3; k++) begin
            set_req(3, ADDR'(32'h800 + k * 8), MEM_BLOCK'(k));
            sample();
            check("t4_o_served", 64'(req_ack), 64'h8);
            next_cycle();
        end
        req_valid[3]      = 1'b0;
        mem2proc_data_tag = 4'd1;
        mem2proc_data     = 64'h0123_4567_89AB_CDEF;
        sample();
        check("t4_q_still_blocked", 64'(req_ack), 64'h0);
        check("t4_rsp_q", 64'(rsp_valid), 64'h1);
        next_cycle();
        mem2proc_data_tag = 4'd0;
        sample();
        check("t4_q_eligible", 64'(req_ack), 64'h1);

        // Out-of-order return to Q and V; a store never yields a response.
        next_cycle();
        do_reset();
        set_req(0, 32'h500, '0);
        mem2proc_transaction_tag = 4'd5;
        sample();
        check("t5_ack_q", 64'(req_ack), 64'h1);
        next_cycle();
        req_valid = '0;
        set_req(2, 32'h600, '0);
        mem2proc_transaction_tag = 4'd6;
        sample();
        check("t5_ack_v", 64'(req_ack), 64'h4);
        next_cycle();
        req_valid = '0;
        set_req(3, 32'h700, 64'hCAFE_F00D_1234_5678);
        mem2proc_transaction_tag = 4'd7;
        sample();
        check("t5_ack_o", 64'(req_ack), 64'h8);
        check("t5_store_cmd", 64'(proc2mem_command), 64'(MEM_STORE));
        check("t5_store_data", proc2mem_data, 64'hCAFE_F00D_1234_5678);
        next_cycle();
        idle_inputs();
        mem2proc_data_tag = 4'd6;
        mem2proc_data     = 64'hAAAA_0000_0000_0006;
        sample();
        check("t5_rsp_v", 64'(rsp_valid), 64'h4);
        check("t5_rsp_v_data", rsp_data, 64'hAAAA_0000_0000_0006);
        next_cycle();
        mem2proc_data_tag = 4'd5;
        mem2proc_data     = 64'hBBBB_0000_0000_0005;
        sample();
        check("t5_rsp_q", 64'(rsp_valid), 64'h1);
        check("t5_rsp_q_data", rsp_data, 64'hBBBB_0000_0000_0005);
        next_cycle();
        mem2proc_data_tag = 4'd7;
        sample();
        check("t5_store_no_rsp", 64'(rsp_valid), 64'h0);
        next_cycle();
        idle_inputs();
        sample();
        check("t5_idle", 64'(idle), 64'd1);

        // Reset with loads in flight; late responses dropped; then tag reuse.
        next_cycle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_valid = '0;
            set_req(i, ADDR'(32'hA00 + i * 8), '0);
            mem2proc_transaction_tag = MEM_TAG'(i + 2);
            sample();
            exp_onehot = '0;
            exp_onehot[i] = 1'b1;
            check("t6_load_ack", 64'(req_ack), 64'(exp_onehot));
            next_cycle();
        end
        req_valid = '0;
        set_req(0, 32'hB00, '0);
        mem2proc_transaction_tag = 4'd8;
        mem2proc_data_tag        = 4'd2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ack", 64'(req_ack), 64'h0);
        check("t6_rst_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
        check("t6_rst_rsp", 64'(rsp_valid), 64'h0);
        check("t6_rst_idle", 64'(idle), 64'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            mem2proc_data_tag = MEM_TAG'(i + 2);
            sample();
            check("t6_stale_dropped", 64'(rsp_valid), 64'h0);
            check("t6_stale_no_err", 64'(err_tag_reuse), 64'd0);
        end
        next_cycle();
        idle_inputs();
        set_req(0, 32'hC00, '0);
        mem2proc_transaction_tag = 4'd9;
        sample();
        check("t6_first_on_9", 64'(req_ack), 64'h1);
        next_cycle();
        req_valid = '0;
        set_req(1, 32'hD00, '0);
        sample();
        check("t6_reuse_ack", 64'(req_ack), 64'h2);
        check("t6_err_not_yet", 64'(err_tag_reuse), 64'd0);
        next_cycle();
        idle_inputs();
        sample();
        check("t6_err_set", 64'(err_tag_reuse), 64'd1);
        repeat (5) next_cycle();
        sample();
        check("t6_err_sticky", 64'(err_tag_reuse), 64'd1);
        next_cycle();
        do_reset();
        sample();
        check("t6_err_cleared", 64'(err_tag_reuse), 64'd0);

        // Randomized traffic against the model, including saturation and a mid-run reset.
        next_cycle();
        run_random(1500, 70, 80, 30, -1);
        run_random(1500, 90, 60, 8, 700);
        run_random(1000, 40, 90, 60, -1);

        sample();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
